// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the RAM port arbiter.
//               rd_tag_t     - which requester owns the read in flight.
//               lock_state_t - ownership state when RAM_ARB_LOCK_EN is set.
//               CNT_W/CNT_MAX - width and saturation value of the wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_REQ0 = 2'd1,
    TAG_REQ1 = 2'd2
  } rd_tag_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_starve_counter
// Description : Saturating count of consecutive cycles requester 1 has been
//               denied. Clears whenever inc_i is low (requester 1 idle or
//               granted). at_limit_o is a pure function of the registered
//               count, so it can feed the grant logic without a loop.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               inc_i       - requester 1 requesting and not granted
//               cnt_o       - current wait count
//               at_limit_o  - cnt_o >= LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_starve_counter
  import ram_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (inc_i) begin
      if (cnt_q == CNT_W'(CNT_MAX)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q >= CNT_W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one synchronous RAM port between the processor
//               load/store path (requester 0) and the loader/DMA path
//               (requester 1). Fixed priority to requester 0, with a
//               starvation counter that forces a grant to requester 1.
//               Reads return one cycle after grant, tagged to the requester.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               reqN/weN/addrN/wdataN       - request fields, held until gnt
//               gntN                        - combinational grant
//               rvalidN/rdataN              - read return
//               ram_address/ram_data/ram_we - RAM drive (word address)
//               ram_read                    - RAM read data
//               starve_cnt                  - requester 1 wait count (debug)
//               lock0/lock1                 - only with RAM_ARB_LOCK_EN
// Config      : define RAM_ARB_LOCK_EN to add bus locking (FREE/OWN0/OWN1).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RAM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_read,
  output logic [CNT_W-1:0]  starve_cnt
);

  logic        w_at_limit;
  logic        w_arb0;
  logic        w_arb1;
  logic        w_gnt0;
  logic        w_gnt1;
  rd_tag_t     rd_tag_d;
  rd_tag_t     rd_tag_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Unlocked arbitration: requester 1 wins only when alone or starved.
  assign w_arb1 = req1 & (~req0 | w_at_limit);
  assign w_arb0 = req0 & ~w_arb1;

`ifdef RAM_ARB_LOCK_EN
  lock_state_t lock_q;
  lock_state_t lock_d;

  always_comb begin
    lock_d = lock_q;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (lock_q)
      OWN0: begin
        w_gnt0 = req0;
        if (req0 && !lock0) lock_d = FREE;
      end
      OWN1: begin
        w_gnt1 = req1;
        if (req1 && !lock1) lock_d = FREE;
      end
      default: begin
        w_gnt0 = w_arb0;
        w_gnt1 = w_arb1;
        if (w_arb0 && lock0) begin
          lock_d = OWN0;
        end else if (w_arb1 && lock1) begin
          lock_d = OWN1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= FREE;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign w_gnt0 = w_arb0;
  assign w_gnt1 = w_arb1;
`endif

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // Counter advances only while requester 1 waits; any other cycle clears it.
  ram_arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (req1 & ~w_gnt1),
    .cnt_o     (starve_cnt),
    .at_limit_o(w_at_limit)
  );

  // RAM drive mux and read-tag capture.
  always_comb begin
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    rd_tag_d    = TAG_NONE;
    if (w_gnt0) begin
      ram_we      = we0;
      ram_address = {2'b00, addr0[ADDR_W-1:2]};
      ram_data    = wdata0;
      rd_tag_d    = we0 ? TAG_NONE : TAG_REQ0;
    end else if (w_gnt1) begin
      ram_we      = we1;
      ram_address = {2'b00, addr1[ADDR_W-1:2]};
      ram_data    = wdata1;
      rd_tag_d    = we1 ? TAG_NONE : TAG_REQ1;
    end
  end

  // rdataN_q remembers the last returned word so rdata holds while rvalid
  // is low; during the return cycle the RAM output passes straight through
  // because the RAM itself supplies the one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag_q <= TAG_NONE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_tag_q <= rd_tag_d;
      if (rd_tag_q == TAG_REQ0) rdata0_q <= ram_read;
      if (rd_tag_q == TAG_REQ1) rdata1_q <= ram_read;
    end
  end

  assign rvalid0 = (rd_tag_q == TAG_REQ0);
  assign rvalid1 = (rd_tag_q == TAG_REQ1);
  assign rdata0  = rvalid0 ? ram_read : rdata0_q;
  assign rdata1  = rvalid1 ? ram_read : rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter. A behavioural model
//               (wait count, pending read owner, held read data) predicts
//               every output from the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_data, ram_read;
  logic [AW-1:0] ram_address;
  logic [3:0]    starve_cnt;
`ifdef RAM_ARB_LOCK_EN
  logic          lock0 = 1'b0;
  logic          lock1 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Model state
  int            m_wait;
  int            m_pend;   // 0 none, 1 read for requester 0, 2 for requester 1
  logic [DW-1:0] m_last0, m_last1;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RAM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ram_address(ram_address),
    .ram_data(ram_data), .ram_we(ram_we), .ram_read(ram_read),
    .starve_cnt(starve_cnt)
  );

  task automatic drive_idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; ram_read = '0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_last0 = '0; m_last1 = '0;
  endtask

  function automatic void exp_gnt(output logic g0, output logic g1);
    g0 = 1'b0; g1 = 1'b0;
    if (req0 && req1) begin
      if (m_wait >= LIM) g1 = 1'b1; else g0 = 1'b1;
    end else begin
      g0 = req0; g1 = req1;
    end
  endfunction

  // Advance the model with the current inputs, then move to posedge+1.
  task automatic advance();
    logic g0, g1;
    exp_gnt(g0, g1);
    if (m_pend == 1) m_last0 = ram_read;
    if (m_pend == 2) m_last1 = ram_read;
    m_pend = (g0 && !we0) ? 1 : ((g1 && !we1) ? 2 : 0);
    m_wait = (req1 && !g1) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    total++; if (ram_address !== '0) begin bad++; $display("FAIL reset_ram_address got=%h exp=0", ram_address); end
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    total++; if (starve_cnt !== 4'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
    total++; if (rdata0 !== '0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    advance();
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rd_gnt0 got=%b exp=1", gnt0); end
    total++; if (ram_address !== 32'h4) begin bad++; $display("FAIL rd_addr got=%h exp=4", ram_address); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", ram_we); end
    advance();
    req0 = 0; ram_read = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL rd_rvalid0 got=%b exp=1", rvalid0); end
    total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata0 got=%h exp=deadbeef", rdata0); end
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL rd_rvalid1 got=%b exp=0", rvalid1); end
    advance();
  endtask

  task automatic test_starvation();
    drive_idle();
    req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (gnt1 !== ((k % 5) == 4)) begin bad++; $display("FAIL starve_gnt1 cyc=%0d got=%b exp=%b", k, gnt1, (k % 5) == 4); end
      total++; if (gnt0 !== ((k % 5) != 4)) begin bad++; $display("FAIL starve_gnt0 cyc=%0d got=%b exp=%b", k, gnt0, (k % 5) != 4); end
      total++; if (starve_cnt !== 4'(k % 5)) begin bad++; $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", k, starve_cnt, k % 5); end
      advance();
    end
    drive_idle();
    advance();
  endtask

  task automatic test_alternating();
    logic [DW-1:0] r;
    r = $urandom;
    drive_idle();
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL alt_gnt1 got=%b exp=1", gnt1); end
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL alt_we_n got=%b exp=1", ram_we); end
    total++; if (ram_address !== 32'h8) begin bad++; $display("FAIL alt_addr got=%h exp=8", ram_address); end
    total++; if (ram_data !== 32'h55) begin bad++; $display("FAIL alt_data got=%h exp=55", ram_data); end
    advance();
    req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 32'h44;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL alt_gnt0 got=%b exp=1", gnt0); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL alt_we_n1 got=%b exp=0", ram_we); end
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL alt_rvalid_n1 got=%b%b exp=00", rvalid0, rvalid1); end
    advance();
    req0 = 0; ram_read = r;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin bad++; $display("FAIL alt_rvalid_n2 got=%b%b exp=10", rvalid0, rvalid1); end
    total++; if (rdata0 !== r) begin bad++; $display("FAIL alt_rdata0 got=%h exp=%h", rdata0, r); end
    advance();
    ram_read = ~r;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL alt_rvalid_n3 got=%b exp=0", rvalid0); end
    total++; if (rdata0 !== r) begin bad++; $display("FAIL alt_rdata_hold got=%h exp=%h", rdata0, r); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    req0 = 1; req1 = 1; addr0 = 32'h30;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rstmid_gnt0 got=%b exp=1", gnt0); end
    advance();
    drive_idle();
    ram_read = 32'h12345678;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL rstmid_pre_rvalid got=%b exp=1", rvalid0); end
    total++; if (starve_cnt !== 4'd1) begin bad++; $display("FAIL rstmid_pre_cnt got=%0d exp=1", starve_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rstmid_in_rvalid got=%b exp=0", rvalid0); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL rstmid_rvalid cyc=%0d got=%b%b exp=00", k, rvalid0, rvalid1); end
      total++; if (starve_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_cnt cyc=%0d got=%0d exp=0", k, starve_cnt); end
      advance();
    end
  endtask

  task automatic test_random();
    logic g0, g1;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_rd0, e_rd1;
    logic          e_rv0, e_rv1;
    logic          lg0, lg1;
    drive_idle();
    lg0 = 1; lg1 = 1;
    for (int c = 0; c < 400; c++) begin
      // A request that was not granted keeps all its fields stable.
      if (!req0 || lg0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = $urandom_range(0, 1);
        addr0 = $urandom; wdata0 = $urandom;
      end
      if (!req1 || lg1) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1);
        addr1 = $urandom; wdata1 = $urandom;
      end
      ram_read = $urandom;
      @(negedge clk);
      exp_gnt(g0, g1);
      e_we   = g0 ? we0 : (g1 ? we1 : 1'b0);
      e_addr = g0 ? (addr0 >> 2) : (g1 ? (addr1 >> 2) : '0);
      e_data = g0 ? wdata0 : (g1 ? wdata1 : '0);
      e_rv0  = (m_pend == 1);
      e_rv1  = (m_pend == 2);
      e_rd0  = e_rv0 ? ram_read : m_last0;
      e_rd1  = e_rv1 ? ram_read : m_last1;
      total++; if (gnt0 !== g0) begin bad++; $display("FAIL rnd_gnt0 cyc=%0d got=%b exp=%b", c, gnt0, g0); end
      total++; if (gnt1 !== g1) begin bad++; $display("FAIL rnd_gnt1 cyc=%0d got=%b exp=%b", c, gnt1, g1); end
      total++; if (ram_we !== e_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, ram_we, e_we); end
      total++; if (ram_address !== e_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, ram_address, e_addr); end
      total++; if (ram_data !== e_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, ram_data, e_data); end
      total++; if (starve_cnt !== 4'(m_wait)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, starve_cnt, m_wait); end
      total++; if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", c, rvalid0, rvalid1, e_rv0, e_rv1); end
      total++; if (rdata0 !== e_rd0) begin bad++; $display("FAIL rnd_rdata0 cyc=%0d got=%h exp=%h", c, rdata0, e_rd0); end
      total++; if (rdata1 !== e_rd1) begin bad++; $display("FAIL rnd_rdata1 cyc=%0d got=%h exp=%h", c, rdata1, e_rd1); end
      lg0 = g0; lg1 = g1;
      advance();
    end
    drive_idle();
    advance();
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    req1 = 1; lock1 = 1;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL lock_take got=%b exp=1", gnt1); end
    @(posedge clk); #1;
    req0 = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("FAIL lock_hold cyc=%0d got=%b%b exp=01", k, gnt0, gnt1); end
      @(posedge clk); #1;
    end
    lock1 = 0;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL lock_release got=%b exp=1", gnt1); end
    @(posedge clk); #1;
    req1 = 0;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL lock_free_gnt0 got=%b exp=1", gnt0); end
    @(posedge clk); #1;
    drive_idle();
  endtask
`endif

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_starvation();
    test_alternating();
    test_reset_mid();
    test_random();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous data-RAM port inside the I/O memory between two requesters.
- Requester 0 is the processor load/store path. Requester 1 is the interpolation loader/DMA path.
- Default policy is fixed priority to requester 0, with a starvation counter that forces a grant to requester 1. Read data returns with a tag after the RAM's 1-cycle latency.
- Sits between the processor/loader and the address decoder's RAM-side signals.

Parameters:
- DATA_W, 32, data width of both requesters and the RAM.
- ADDR_W, 32, byte-address width of the requesters and of the RAM word-address output.
- STARVE_LIMIT, 4, consecutive denied cycles of requester 1 after which it is forced the grant (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; the access is accepted in the cycle gnt is high
- rvalid0 / rvalid1  out  1  read data valid, registered
- rdata0 / rdata1  out  DATA_W  read data, valid while rvalid is high
- ram_address  out  ADDR_W  word address = granted byte address >> 2, zero-extended
- ram_data  out  DATA_W  granted write data
- ram_we  out  1  granted write strobe
- ram_read  in  DATA_W  RAM read data, valid one cycle after address
- starve_cnt  out  4  current requester-1 wait count (debug)

Behaviour:
- Reset (async, rst_n=0):
  - starve_cnt=0, rd_tag=NONE, rvalid0=rvalid1=0, rdata0=rdata1=0, lock owner=NONE.
  - Combinational outputs follow from the reset state: with no requests, gnt0=gnt1=0, ram_we=0, ram_address=0, ram_data=0.
- Grant rule, evaluated combinationally each cycle:
  - only req0: gnt0=1
  - only req1: gnt1=1
  - both, starve_cnt < STARVE_LIMIT: gnt0=1
  - both, starve_cnt >= STARVE_LIMIT: gnt1=1
  - At most one gnt high per cycle.
- RAM drive:
  - ram_address, ram_data and ram_we are muxed from the granted requester.
  - ram_we = we & gnt.
  - With no grant: ram_we=0, ram_address=0, ram_data=0.
- Starvation counter:
  - Increments, saturating at 15, when req1=1 and gnt1=0.
  - Clears to 0 on any cycle with gnt1=1 or with req1=0.
- Read return:
  - A granted read registers rd_tag = requester id. A write or an idle cycle registers NONE.
  - Next cycle: rvalid of the tagged requester = 1 and its rdata = ram_read. All other rvalid = 0.
  - rdata holds its last value while rvalid is low.
- Pipelining:
  - Back-to-back grants are allowed every cycle, from either requester.
  - Read latency is exactly 1 cycle after grant; throughput is 1 access per cycle.
- Simultaneous events:
  - A grant in cycle N and a read return for cycle N-1 coexist. No stall is introduced.
- Reset mid-operation:
  - An in-flight read is dropped: no rvalid after rst_n deasserts.
  - The counter restarts at 0.
- Requesters must keep req, we, addr and wdata stable until gnt. The arbiter does not latch request fields.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - Adds input ports lock0 and lock1 (1 bit each).
  - A granted requester with lock=1 becomes owner (3-state FSM: FREE, OWN0, OWN1).
  - In OWNx, only requester x can be granted, regardless of priority or the starvation counter. The counter keeps counting but cannot force a grant.
  - Ownership returns to FREE on the first cycle owner x presents req=1 with lock=0; that access is still granted.
  - Ownership also returns to FREE on reset.
- Undefined:
  - No lock ports and no FSM. Arbitration is exactly as in Behaviour.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum {TAG_NONE, TAG_REQ0, TAG_REQ1} rd_tag_t
  - typedef enum {FREE, OWN0, OWN1} lock_state_t
  - localparam CNT_W=4, CNT_MAX=15
- One natural sub-module: ram_arb_starve_counter (saturating wait counter with clear and threshold compare).
- The grant mux stays in the top level.

Test Plan:
- Reset release with no requests -> gnt0=gnt1=0, ram_we=0, ram_address=0, rvalid0=rvalid1=0, starve_cnt=0.
- req0 read addr0=0x10 -> gnt0=1 and ram_address=0x4 in the same cycle; model ram_read=0xDEADBEEF next cycle -> rvalid0=1, rdata0=0xDEADBEEF, rvalid1=0.
- req0 and req1 held high with STARVE_LIMIT=4:
  - gnt0 for 4 cycles, starve_cnt 0,1,2,3,4
  - 5th cycle gnt1=1, starve_cnt returns to 0 the following cycle
  - pattern repeats 4:1.
- Alternating grants: req1 write addr1=0x20, wdata1=0x55 in cycle N, then req0 read in N+1 -> ram_we=1, ram_address=0x8, ram_data=0x55 in N; ram_we=0 in N+1; rvalid0 in N+2 only, no rvalid1.
- rst_n pulled low in the cycle after a granted read -> no rvalid0 after release; starve_cnt=0.
- RAM_ARB_LOCK_EN defined:
  - req1 with lock1=1 granted
  - then req0 and req1 with lock1=1 for 8 cycles -> gnt1 every cycle, gnt0=0
  - req1 with lock1=0 -> granted, FSM back to FREE, next cycle gnt0=1.
